adc3663_spi_cmd_sched: RTL and testbench
========================================

Name: adc3663_spi_cmd_sched

Overview:
Command scheduler in front of the ADC3663 3-wire SPI serial interface. It buffers PS register commands in a FIFO and shares the single SPI engine between those commands and a periodic readback poller. It drives the engine's request, config, rw and data inputs, then closes each transaction on the engine's ack pulses. Read results are returned to the PS and to a poll status register.

Parameters:
FIFO_DEPTH, 16, PS command FIFO entries; power of 2, minimum 2.
POLL_PERIOD, 1000000, sys_clk cycles between poll read requests.
TIMEOUT_CYCLES, 4096, sys_clk cycles from ISSUE to ack before the transaction is aborted.
GAP_CYCLES, 40, minimum idle sys_clk cycles between transactions (4 spi_clk cycles).
RD_SETTLE, 20, sys_clk cycles after the read-ack rising edge before spi_pdata_i is sampled.

Ports:
sys_clk  in  1  100 MHz clock; the SPI engine's 10 MHz spi_clk is derived from it and phase-related.
sys_rst  in  1  asynchronous, active-high reset.
cmd_wr_en  in  1  PS push strobe; ignored when cmd_full=1.
cmd_wr_data  in  23  {rw(1: read), addr[13:0], data[7:0]}.
cmd_full  out  1  FIFO full.
cmd_level  out  log2(FIFO_DEPTH)+1  FIFO occupancy.
poll_en  in  1  enables periodic readback.
poll_addr  in  14  register address read by the poller.
spi_wr_ack_i  in  1  engine write-done pulse, one spi_clk period wide.
spi_rd_ack_i  in  1  engine read-done pulse, one spi_clk period wide.
spi_pdata_i  in  8  engine read-data register.
adcfifo_empty_o  out  1  to the engine; 0 = request pending.
spi_config_o  out  1  to the engine; held high for the whole transaction.
spi_rw_flag_o  out  1  to the engine; 0 = write, 1 = read.
adc_data_o  out  22  to the engine; {addr, data}.
rd_valid_o  out  1  one-cycle pulse; a PS read result is valid.
rd_addr_o  out  14  address of the PS read result.
rd_data_o  out  8  data of the PS read result.
poll_data_o  out  8  last polled value.
poll_valid_o  out  1  one-cycle pulse when poll_data_o updates.
busy_o  out  1  state is not IDLE.
timeout_err_o  out  1  sticky; set when a transaction times out.
err_clr  in  1  clears timeout_err_o.

Behaviour:
- Reset values: adcfifo_empty_o=1; spi_config_o=0; spi_rw_flag_o=0; adc_data_o=0; all valid pulses=0; rd_addr_o=0; rd_data_o=0; poll_data_o=0; busy_o=0; timeout_err_o=0; cmd_full=0; cmd_level=0. FIFO pointers, poll timer and poll_pending are cleared.
- Reset asserted mid-transaction aborts immediately to these values; nothing is replayed.
- FIFO: a push when full is dropped and the level is unchanged. A simultaneous push and pop keeps the level unchanged. Pointers wrap modulo FIFO_DEPTH.
- Poll timer: counts only while poll_en=1. When it reaches POLL_PERIOD-1 it sets poll_pending and wraps to 0. If poll_pending is already set, the new tick is absorbed. poll_en=0 clears the timer and poll_pending.
- Ack detection: the block rising-edge detects spi_wr_ack_i and spi_rd_ack_i using one registered copy of each. Each ack pulse counts exactly once.
- State IDLE:
  - If the FIFO is non-empty, pop the head and go to ISSUE. The FIFO has strict priority.
  - Otherwise, if poll_pending=1, load {rw=1, poll_addr, 8'h00}, mark the source as POLL, clear poll_pending and go to ISSUE.
- State ISSUE (entered with latency 1 after the decision):
  - Drive adc_data_o and spi_rw_flag_o, set adcfifo_empty_o=0 and spi_config_o=1.
  - These outputs are held stable until the transaction ends.
  - Start the timeout counter and go to WAIT_ACK.
- State WAIT_ACK:
  - For a write, the wr-ack edge goes to GAP.
  - For a read, the rd-ack edge goes to SETTLE.
  - An ack edge of the wrong type is ignored.
- State SETTLE: after RD_SETTLE cycles, sample spi_pdata_i.
  - PS source: rd_addr_o = command address, rd_data_o = sample, one-cycle rd_valid_o.
  - POLL source: poll_data_o = sample, one-cycle poll_valid_o.
  - Then go to GAP.
- State GAP: set adcfifo_empty_o=1 and spi_config_o=0 on entry. Remain for GAP_CYCLES, then go to IDLE.
- Timeout: if the timeout counter reaches TIMEOUT_CYCLES in WAIT_ACK or SETTLE, set timeout_err_o and go to GAP with no result pulse. The command is discarded.
- timeout_err_o: err_clr clears it. If err_clr and a timeout occur in the same cycle, set wins.
- busy_o = (state != IDLE), registered.
- No combinational path exists from any input to any output.

Test Plan:
- Write: push {0, 14'h0013, 8'hA5} -> adc_data_o=22'h0013A5, spi_rw_flag_o=0, spi_config_o=1 and adcfifo_empty_o=0 until the wr-ack edge, then a GAP of 40 cycles and busy_o low again; no rd_valid_o.
- Read: push {1, 14'h0020, x}; model returns 8'h3C on rd-ack -> 20 cycles after the ack edge, rd_valid_o pulses once with rd_addr_o=14'h0020 and rd_data_o=8'h3C.
- Overflow: with the engine stalled, push 17 commands -> cmd_full after the 16th, the 17th is dropped, cmd_level=16. Draining 16 commands issues them in push order.
- Arbitration: set POLL_PERIOD=200 and keep the FIFO non-empty through a poll tick -> the poll is deferred until the FIFO is empty, then exactly one poll read of poll_addr; poll_valid_o pulses with the model value.
- Timeout: the model never acks -> after 4096 cycles timeout_err_o=1, adcfifo_empty_o=1, and the next FIFO command issues. err_clr clears the flag; err_clr coincident with a second timeout leaves it at 1.
- Reset: assert sys_rst during SETTLE -> all outputs return to reset values asynchronously, FIFO is empty, and no rd_valid_o occurs after release.

Source files
------------

// File: rtl/adc3663_spi_cmd_sched.sv
// Command scheduler for the ADC3663 SPI engine: buffers PS register commands,
// interleaves periodic readback polls and closes each transaction on engine acks.
module adc3663_spi_cmd_sched #(
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned POLL_PERIOD    = 1000000,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned GAP_CYCLES     = 40,
  parameter int unsigned RD_SETTLE      = 20
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic                          cmd_wr_en,
  input  logic [22:0]                   cmd_wr_data,
  output logic                          cmd_full,
  output logic [$clog2(FIFO_DEPTH):0]   cmd_level,
  input  logic                          poll_en,
  input  logic [13:0]                   poll_addr,
  input  logic                          spi_wr_ack_i,
  input  logic                          spi_rd_ack_i,
  input  logic [7:0]                    spi_pdata_i,
  output logic                          adcfifo_empty_o,
  output logic                          spi_config_o,
  output logic                          spi_rw_flag_o,
  output logic [21:0]                   adc_data_o,
  output logic                          rd_valid_o,
  output logic [13:0]                   rd_addr_o,
  output logic [7:0]                    rd_data_o,
  output logic [7:0]                    poll_data_o,
  output logic                          poll_valid_o,
  output logic                          busy_o,
  output logic                          timeout_err_o,
  input  logic                          err_clr
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned PW = $clog2(POLL_PERIOD + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
  localparam int unsigned SW = $clog2(RD_SETTLE + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, SETTLE, GAP} state_t;

  state_t          state;
  logic [22:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   level_nxt;
  logic            push;
  logic            pop;
  logic [PW-1:0]   poll_timer;
  logic            poll_pending;
  logic            poll_take;
  logic            wr_ack_q;
  logic            rd_ack_q;
  logic            wr_edge;
  logic            rd_edge;
  logic            cur_rw;
  logic [13:0]     cur_addr;
  logic [7:0]      cur_data;
  logic            cur_poll;
  logic [TW-1:0]   tmo_cnt;
  logic            tmo_hit;
  logic [GW-1:0]   gap_cnt;
  logic [SW-1:0]   settle_cnt;

  assign push      = cmd_wr_en && !cmd_full;
  assign pop       = (state == IDLE) && (cmd_level != '0);
  assign poll_take = (state == IDLE) && (cmd_level == '0) && poll_pending && poll_en;
  assign wr_edge   = spi_wr_ack_i && !wr_ack_q;
  assign rd_edge   = spi_rd_ack_i && !rd_ack_q;
  assign tmo_hit   = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    level_nxt = cmd_level;
    if (push && !pop)
      level_nxt = cmd_level + LW'(1);
    else if (pop && !push)
      level_nxt = cmd_level - LW'(1);
  end

  // FIFO pointers and occupancy; full is registered from the next level
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cmd_level <= '0;
      cmd_full  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      cmd_level <= level_nxt;
      cmd_full  <= (level_nxt == LW'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr] <= cmd_wr_data;
  end

  // A tick coinciding with a take re-arms the request
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      poll_timer   <= '0;
      poll_pending <= 1'b0;
    end else if (!poll_en) begin
      poll_timer   <= '0;
      poll_pending <= 1'b0;
    end else if (poll_timer == PW'(POLL_PERIOD - 1)) begin
      poll_timer   <= '0;
      poll_pending <= 1'b1;
    end else begin
      poll_timer <= poll_timer + PW'(1);
      if (poll_take) poll_pending <= 1'b0;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ack_q <= 1'b0;
      rd_ack_q <= 1'b0;
    end else begin
      wr_ack_q <= spi_wr_ack_i;
      rd_ack_q <= spi_rd_ack_i;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state           <= IDLE;
      cur_rw          <= 1'b0;
      cur_addr        <= '0;
      cur_data        <= '0;
      cur_poll        <= 1'b0;
      tmo_cnt         <= '0;
      gap_cnt         <= '0;
      settle_cnt      <= '0;
      adcfifo_empty_o <= 1'b1;
      spi_config_o    <= 1'b0;
      spi_rw_flag_o   <= 1'b0;
      adc_data_o      <= '0;
      rd_valid_o      <= 1'b0;
      rd_addr_o       <= '0;
      rd_data_o       <= '0;
      poll_data_o     <= '0;
      poll_valid_o    <= 1'b0;
      busy_o          <= 1'b0;
      timeout_err_o   <= 1'b0;
    end else begin
      rd_valid_o   <= 1'b0;
      poll_valid_o <= 1'b0;
      if (err_clr) timeout_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            {cur_rw, cur_addr, cur_data} <= mem[rd_ptr];
            cur_poll <= 1'b0;
            state    <= ISSUE;
            busy_o   <= 1'b1;
          end else if (poll_take) begin
            cur_rw   <= 1'b1;
            cur_addr <= poll_addr;
            cur_data <= '0;
            cur_poll <= 1'b1;
            state    <= ISSUE;
            busy_o   <= 1'b1;
          end
        end
        ISSUE: begin
          adc_data_o      <= {cur_addr, cur_data};
          spi_rw_flag_o   <= cur_rw;
          adcfifo_empty_o <= 1'b0;
          spi_config_o    <= 1'b1;
          tmo_cnt         <= '0;
          state           <= WAIT_ACK;
        end
        WAIT_ACK: begin
          tmo_cnt <= tmo_cnt + TW'(1);
          if (tmo_hit) begin
            timeout_err_o   <= 1'b1;
            adcfifo_empty_o <= 1'b1;
            spi_config_o    <= 1'b0;
            gap_cnt         <= '0;
            state           <= GAP;
          end else if (cur_rw && rd_edge) begin
            settle_cnt <= '0;
            state      <= SETTLE;
          end else if (!cur_rw && wr_edge) begin
            adcfifo_empty_o <= 1'b1;
            spi_config_o    <= 1'b0;
            gap_cnt         <= '0;
            state           <= GAP;
          end
        end
        SETTLE: begin
          tmo_cnt <= tmo_cnt + TW'(1);
          if (tmo_hit) begin
            timeout_err_o   <= 1'b1;
            adcfifo_empty_o <= 1'b1;
            spi_config_o    <= 1'b0;
            gap_cnt         <= '0;
            state           <= GAP;
          end else if (settle_cnt == SW'(RD_SETTLE - 1)) begin
            if (cur_poll) begin
              poll_data_o  <= spi_pdata_i;
              poll_valid_o <= 1'b1;
            end else begin
              rd_addr_o  <= cur_addr;
              rd_data_o  <= spi_pdata_i;
              rd_valid_o <= 1'b1;
            end
            adcfifo_empty_o <= 1'b1;
            spi_config_o    <= 1'b0;
            gap_cnt         <= '0;
            state           <= GAP;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc3663_spi_cmd_sched.sv
// Bench for adc3663_spi_cmd_sched: behavioural SPI engine, issue/result
// scoreboard queues, a vector table and hand-written corner-case sequences.
module tb_adc3663_spi_cmd_sched;

  localparam int unsigned FIFO_DEPTH     = 16;
  localparam int unsigned POLL_PERIOD    = 200;
  localparam int unsigned TIMEOUT_CYCLES = 4096;
  localparam int unsigned GAP_CYCLES     = 40;
  localparam int unsigned RD_SETTLE      = 20;
  localparam int unsigned ENG_LAT        = 6;
  localparam int unsigned LW             = $clog2(FIFO_DEPTH) + 1;
  localparam int          NV             = 6;

  logic          sys_clk;
  logic          sys_rst;
  logic          cmd_wr_en;
  logic [22:0]   cmd_wr_data;
  logic          cmd_full;
  logic [LW-1:0] cmd_level;
  logic          poll_en;
  logic [13:0]   poll_addr;
  logic          spi_wr_ack_i;
  logic          spi_rd_ack_i;
  logic [7:0]    spi_pdata_i;
  logic          adcfifo_empty_o;
  logic          spi_config_o;
  logic          spi_rw_flag_o;
  logic [21:0]   adc_data_o;
  logic          rd_valid_o;
  logic [13:0]   rd_addr_o;
  logic [7:0]    rd_data_o;
  logic [7:0]    poll_data_o;
  logic          poll_valid_o;
  logic          busy_o;
  logic          timeout_err_o;
  logic          err_clr;

  adc3663_spi_cmd_sched #(
    .FIFO_DEPTH(FIFO_DEPTH), .POLL_PERIOD(POLL_PERIOD), .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .GAP_CYCLES(GAP_CYCLES), .RD_SETTLE(RD_SETTLE)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cmd_wr_en(cmd_wr_en), .cmd_wr_data(cmd_wr_data),
    .cmd_full(cmd_full), .cmd_level(cmd_level), .poll_en(poll_en), .poll_addr(poll_addr),
    .spi_wr_ack_i(spi_wr_ack_i), .spi_rd_ack_i(spi_rd_ack_i), .spi_pdata_i(spi_pdata_i),
    .adcfifo_empty_o(adcfifo_empty_o), .spi_config_o(spi_config_o),
    .spi_rw_flag_o(spi_rw_flag_o), .adc_data_o(adc_data_o), .rd_valid_o(rd_valid_o),
    .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .poll_data_o(poll_data_o),
    .poll_valid_o(poll_valid_o), .busy_o(busy_o), .timeout_err_o(timeout_err_o),
    .err_clr(err_clr)
  );

  typedef struct {
    logic        rw;
    logic [13:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic [21:0] exp_adc;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t        vecs [NV];
  logic [22:0] exp_issue [$];
  logic [21:0] exp_rd [$];
  logic [7:0]  exp_poll [$];

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          ack_cyc = 0;
  int          issue_cyc = 0;
  int          gap_start_cyc = 0;
  int          rd_cnt = 0;
  int          rd_snap = 0;
  logic        eng_ack_en;
  logic [7:0]  eng_rdata;
  logic        prev_empty = 1'b1;
  logic [22:0] cur_issue = '0;
  logic [22:0] e_issue;
  logic [21:0] e_rd;
  logic [7:0]  e_poll;

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_cmd(input logic rw, input logic [13:0] addr, input logic [7:0] data);
    cmd_wr_en   = 1'b1;
    cmd_wr_data = {rw, addr, data};
    @(negedge sys_clk);
    cmd_wr_en   = 1'b0;
  endtask

  task automatic wait_txn(input string name);
    int n;
    n = 0;
    while (!busy_o && n < 50) begin @(negedge sys_clk); n++; end
    chk({name, "_busy_rise"}, 32'(busy_o), 32'd1);
    n = 0;
    while (busy_o && n < 6000) begin @(negedge sys_clk); n++; end
    chk({name, "_busy_fall"}, 32'(busy_o), 32'd0);
  endtask

  task automatic wait_err(input string name);
    int n;
    n = 0;
    while (!timeout_err_o && n < int'(TIMEOUT_CYCLES) + 200) begin @(negedge sys_clk); n++; end
    chk(name, 32'(timeout_err_o), 32'd1);
  endtask

  // Engine model: ack one spi_clk (10 sys_clk) wide, ENG_LAT cycles after the request
  initial begin
    spi_wr_ack_i = 1'b0;
    spi_rd_ack_i = 1'b0;
    spi_pdata_i  = '0;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst && !adcfifo_empty_o && eng_ack_en) begin
        repeat (ENG_LAT) @(negedge sys_clk);
        if (!sys_rst && !adcfifo_empty_o) begin
          spi_pdata_i = eng_rdata;
          ack_cyc = cyc;
          if (spi_rw_flag_o) spi_rd_ack_i = 1'b1;
          else               spi_wr_ack_i = 1'b1;
          repeat (10) @(negedge sys_clk);
          spi_wr_ack_i = 1'b0;
          spi_rd_ack_i = 1'b0;
          for (int w = 0; w < 200 && !sys_rst && !adcfifo_empty_o; w++) @(negedge sys_clk);
        end
      end
    end
  end

  // Scoreboard monitor: issues, held request payload, results
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (prev_empty && !adcfifo_empty_o) begin
        issue_cyc = cyc;
        if (exp_issue.size() == 0) chk("issue_unexpected", 32'(adcfifo_empty_o), 32'd1);
        else begin
          e_issue   = exp_issue.pop_front();
          cur_issue = e_issue;
          chk("issue_payload", 32'({spi_rw_flag_o, adc_data_o}), 32'(e_issue));
          chk("issue_config", 32'(spi_config_o), 32'd1);
        end
      end else if (!prev_empty && !adcfifo_empty_o) begin
        chk("issue_hold", 32'({spi_config_o, spi_rw_flag_o, adc_data_o}), 32'({1'b1, cur_issue}));
      end
      if (!prev_empty && adcfifo_empty_o) begin
        gap_start_cyc = cyc;
        chk("gap_config_low", 32'(spi_config_o), 32'd0);
      end
      if (rd_valid_o) begin
        rd_cnt++;
        if (exp_rd.size() == 0) chk("rd_valid_unexpected", 32'(rd_valid_o), 32'd0);
        else begin
          e_rd = exp_rd.pop_front();
          chk("rd_addr", 32'(rd_addr_o), 32'(e_rd[21:8]));
          chk("rd_data", 32'(rd_data_o), 32'(e_rd[7:0]));
          chk("rd_latency", 32'(cyc - ack_cyc), RD_SETTLE + 1);
        end
      end
      if (poll_valid_o) begin
        if (exp_poll.size() == 0) chk("poll_valid_unexpected", 32'(poll_valid_o), 32'd0);
        else begin
          e_poll = exp_poll.pop_front();
          chk("poll_data", 32'(poll_data_o), 32'(e_poll));
          chk("poll_latency", 32'(cyc - ack_cyc), RD_SETTLE + 1);
        end
      end
    end
    prev_empty = adcfifo_empty_o;
  end

  initial begin
    sys_rst = 1'b1; cmd_wr_en = 1'b0; cmd_wr_data = '0; poll_en = 1'b0; poll_addr = '0;
    err_clr = 1'b0; eng_ack_en = 1'b1; eng_rdata = '0;
    vecs[0] = '{1'b0, 14'h0013, 8'hA5, 8'h00, 22'h0013A5, 8'h00};
    vecs[1] = '{1'b1, 14'h0020, 8'h00, 8'h3C, 22'h002000, 8'h3C};
    vecs[2] = '{1'b0, 14'h3FFF, 8'hFF, 8'h00, 22'h3FFFFF, 8'h00};
    vecs[3] = '{1'b1, 14'h0000, 8'h00, 8'h00, 22'h000000, 8'h00};
    vecs[4] = '{1'b1, 14'h1ABC, 8'h5F, 8'hC3, 22'h1ABC5F, 8'hC3};
    vecs[5] = '{1'b0, 14'h0001, 8'h00, 8'h00, 22'h000100, 8'h00};
    repeat (3) @(negedge sys_clk);

    chk("rst_empty",  32'(adcfifo_empty_o), 32'd1);
    chk("rst_outs",   32'({spi_config_o, spi_rw_flag_o, rd_valid_o, poll_valid_o, busy_o,
                           timeout_err_o, cmd_full}), 32'd0);
    chk("rst_data",   32'(adc_data_o), 32'd0);
    chk("rst_rd",     32'({rd_addr_o, rd_data_o}), 32'd0);
    chk("rst_poll",   32'(poll_data_o), 32'd0);
    chk("rst_level",  32'(cmd_level), 32'd0);
    sys_rst = 1'b0;
    @(negedge sys_clk);

    // Vector table: single writes and reads through the whole transaction
    for (int i = 0; i < NV; i++) begin
      eng_rdata = vecs[i].rdata;
      exp_issue.push_back({vecs[i].rw, vecs[i].exp_adc});
      if (vecs[i].rw) exp_rd.push_back({vecs[i].addr, vecs[i].exp_rd});
      push_cmd(vecs[i].rw, vecs[i].addr, vecs[i].wdata);
      wait_txn("vec");
      chk("vec_gap_len", 32'(cyc - gap_start_cyc), GAP_CYCLES);
      chk("vec_idle_outs", 32'({adcfifo_empty_o, spi_config_o}), 32'b10);
    end
    chk("vec_rd_count", 32'(rd_cnt), 32'd3);

    // Overflow: sentinel stalls the engine, then 17 pushes
    eng_ack_en = 1'b0;
    exp_issue.push_back({1'b0, 14'h3F00, 8'h00});
    push_cmd(1'b0, 14'h3F00, 8'h00);
    repeat (3) @(negedge sys_clk);
    chk("ovf_sentinel_busy", 32'(busy_o), 32'd1);
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_issue.push_back({1'b0, 14'(14'h0100 + i), 8'(8'h30 + i)});
      push_cmd(1'b0, 14'(14'h0100 + i), 8'(8'h30 + i));
      chk("ovf_level", 32'(cmd_level), 32'((i < 16) ? i + 1 : 16));
      chk("ovf_full",  32'(cmd_full),  32'((i >= 15) ? 1 : 0));
    end
    wait_err("ovf_sentinel_timeout");
    err_clr = 1'b1; @(negedge sys_clk); err_clr = 1'b0;
    eng_ack_en = 1'b1;
    for (int n = 0; n < 5000 && (cmd_level != '0 || busy_o); n++) @(negedge sys_clk);
    chk("ovf_drained", 32'({busy_o, cmd_level}), 32'd0);
    chk("ovf_all_issued", 32'(exp_issue.size()), 32'd0);

    // Arbitration: poll tick while FIFO busy is deferred, then exactly one poll
    poll_addr = 14'h0155;
    eng_rdata = 8'h5A;
    poll_en   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_issue.push_back({1'b0, 14'(14'h0200 + i), 8'(8'hC0 + i)});
      push_cmd(1'b0, 14'(14'h0200 + i), 8'(8'hC0 + i));
    end
    exp_issue.push_back({1'b1, 14'h0155, 8'h00});
    exp_poll.push_back(8'h5A);
    repeat (190) @(negedge sys_clk);
    chk("arb_fifo_busy_at_tick", 32'(cmd_level != '0), 32'd1);
    for (int n = 0; n < 1000 && !poll_valid_o; n++) @(negedge sys_clk);
    chk("arb_poll_seen", 32'(poll_valid_o), 32'd1);
    poll_en = 1'b0;
    repeat (300) @(negedge sys_clk);
    chk("arb_poll_data_held", 32'(poll_data_o), 32'h5A);
    chk("arb_queues_empty", 32'(exp_issue.size() + exp_poll.size()), 32'd0);
    chk("arb_idle", 32'(busy_o), 32'd0);

    // Timeout: two stalled writes, err_clr, then set-wins
    eng_ack_en = 1'b0;
    exp_issue.push_back({1'b0, 14'h000A, 8'h11});
    exp_issue.push_back({1'b0, 14'h000B, 8'h22});
    push_cmd(1'b0, 14'h000A, 8'h11);
    push_cmd(1'b0, 14'h000B, 8'h22);
    wait_err("tmo1_set");
    chk("tmo1_latency", 32'(cyc - issue_cyc), TIMEOUT_CYCLES);
    chk("tmo1_released", 32'({adcfifo_empty_o, spi_config_o}), 32'b10);
    err_clr = 1'b1; @(negedge sys_clk); err_clr = 1'b0;
    chk("tmo1_cleared", 32'(timeout_err_o), 32'd0);
    err_clr = 1'b1;
    wait_err("tmo2_set_wins");
    err_clr = 1'b0;
    chk("tmo2_next_issued", 32'(exp_issue.size()), 32'd0);
    @(negedge sys_clk);
    chk("tmo2_sticky", 32'(timeout_err_o), 32'd1);
    err_clr = 1'b1; @(negedge sys_clk); err_clr = 1'b0;
    chk("tmo2_cleared", 32'(timeout_err_o), 32'd0);
    eng_ack_en = 1'b1;
    for (int n = 0; n < 200 && busy_o; n++) @(negedge sys_clk);
    chk("tmo_idle", 32'(busy_o), 32'd0);

    // Reset during SETTLE: asynchronous abort, FIFO emptied, no late result
    eng_rdata = 8'h77;
    exp_issue.push_back({1'b1, 14'h0042, 8'h00});
    exp_rd.push_back({14'h0042, 8'h77});
    push_cmd(1'b1, 14'h0042, 8'h00);
    push_cmd(1'b1, 14'h0043, 8'h00);
    for (int n = 0; n < 60 && !spi_rd_ack_i; n++) @(negedge sys_clk);
    repeat (10) @(negedge sys_clk);
    chk("rst_pre_state", 32'({busy_o, cmd_level}), 32'({1'b1, LW'(1)}));
    #2 sys_rst = 1'b1;
    #1;
    chk("arst_empty", 32'(adcfifo_empty_o), 32'd1);
    chk("arst_outs",  32'({spi_config_o, spi_rw_flag_o, rd_valid_o, busy_o, cmd_full}), 32'd0);
    chk("arst_data",  32'(adc_data_o), 32'd0);
    chk("arst_poll",  32'(poll_data_o), 32'd0);
    chk("arst_level", 32'(cmd_level), 32'd0);
    exp_issue.delete();
    exp_rd.delete();
    rd_snap = rd_cnt;
    @(negedge sys_clk); @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (150) @(negedge sys_clk);
    chk("rst_no_rd_valid", 32'(rd_cnt - rd_snap), 32'd0);
    chk("rst_stays_idle", 32'({busy_o, cmd_level}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
